// File: rtl/apb_mem_slave_p_if.sv
// APB-side bus bundle for apb_mem_slave_p.
// It carries the select/enable/address/data request fields and the ready/rdata/slverr response fields.
interface apb_mem_slave_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int WAIT_W = 8
);
  logic [SEL_W-1:0]  sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [WAIT_W-1:0] wait_cycles;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              slverr;

  modport master (
    output sel, enable, write, addr, wdata, wait_cycles,
    input  ready, rdata, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata, wait_cycles,
    output ready, rdata, slverr
  );
endinterface

// File: rtl/apb_mem_slave_p.sv
// APB slave bridging one select code to a synchronous single-port memory.
// It adds wait states, a read-capture stage, an out-of-range error response and sticky protocol-violation detection.
module apb_mem_slave_p #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int ID     = 1,
  parameter int DEPTH  = 256,
  parameter int WAIT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  apb_mem_slave_p_if.slave    bus,
  output logic                proto_err,
  output logic                mem_ce,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_MEM  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] ID_CODE   = SEL_W'(ID);
  // One extra bit so DEPTH == 2**ADDR_W never flags an address as out of range.
  localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state_r, state_nxt_s;
  logic [WAIT_W-1:0] cnt_r, cnt_nxt_s;
  logic              wr_r, wr_nxt_s;
  logic              oor_r, oor_nxt_s;
  logic              viol_s;
  logic              hit_s, setup_s, access_s;

  logic              ready_r, ready_nxt_s;
  logic              slverr_r, slverr_nxt_s;
  logic              proto_err_r, proto_err_nxt_s;
  logic              ce_r, ce_nxt_s;
  logic              wren_r, wren_nxt_s;
  logic              rden_r, rden_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
  logic [DATA_W-1:0] rdata_r, rdata_nxt_s;

  assign hit_s    = (bus.sel == ID_CODE);
  assign setup_s  = hit_s && !bus.enable;
  assign access_s = hit_s && bus.enable;

  // State register with the per-transfer latch and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      wr_r    <= 1'b0;
      oor_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      wr_r    <= wr_nxt_s;
      oor_r   <= oor_nxt_s;
    end
  end

  // Next-state logic; any loss of sel/enable after setup aborts to IDLE
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wr_nxt_s    = wr_r;
    oor_nxt_s   = oor_r;
    viol_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) begin
          wr_nxt_s    = bus.write;
          oor_nxt_s   = ({1'b0, bus.addr} >= DEPTH_LIM);
          cnt_nxt_s   = bus.wait_cycles;
          state_nxt_s = (bus.wait_cycles != '0) ? ST_WAIT : ST_MEM;
        end else begin
          viol_s = access_s;
        end
      end
      ST_WAIT: begin
        if (!access_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          viol_s      = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r - WAIT_W'(1);
          state_nxt_s = (cnt_r == WAIT_W'(1)) ? ST_MEM : ST_WAIT;
        end
      end
      ST_MEM: begin
        if (!access_s) begin
          state_nxt_s = ST_IDLE;
          viol_s      = 1'b1;
        end else begin
          state_nxt_s = (!oor_r && !wr_r) ? ST_CAPT : ST_RESP;
        end
      end
      ST_CAPT: begin
        if (!access_s) begin
          state_nxt_s = ST_IDLE;
          viol_s      = 1'b1;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop
  always_comb begin
    ce_nxt_s        = (state_nxt_s == ST_MEM) && !oor_nxt_s;
    wren_nxt_s      = ce_nxt_s && wr_nxt_s;
    rden_nxt_s      = ce_nxt_s && !wr_nxt_s;
    ready_nxt_s     = (state_nxt_s == ST_RESP);
    slverr_nxt_s    = ready_nxt_s && oor_nxt_s;
    proto_err_nxt_s = proto_err_r || viol_s;
    if ((state_r == ST_IDLE) && setup_s) begin
      addr_nxt_s  = bus.addr;
      wdata_nxt_s = bus.wdata;
    end else begin
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
    end
    if ((state_r == ST_CAPT) && (state_nxt_s == ST_RESP)) begin
      rdata_nxt_s = mem_rdata;
    end else if (ready_nxt_s && oor_nxt_s && !wr_nxt_s) begin
      rdata_nxt_s = '0;
    end else begin
      rdata_nxt_s = rdata_r;
    end
  end

  // Output registers; asynchronous reset drops every strobe immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r     <= 1'b0;
      slverr_r    <= 1'b0;
      proto_err_r <= 1'b0;
      ce_r        <= 1'b0;
      wren_r      <= 1'b0;
      rden_r      <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      rdata_r     <= '0;
    end else begin
      ready_r     <= ready_nxt_s;
      slverr_r    <= slverr_nxt_s;
      proto_err_r <= proto_err_nxt_s;
      ce_r        <= ce_nxt_s;
      wren_r      <= wren_nxt_s;
      rden_r      <= rden_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      rdata_r     <= rdata_nxt_s;
    end
  end

  assign bus.ready  = ready_r;
  assign bus.slverr = slverr_r;
  assign bus.rdata  = rdata_r;
  assign proto_err  = proto_err_r;
  assign mem_ce     = ce_r;
  assign mem_wren   = wren_r;
  assign mem_rden   = rden_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Directed bench for apb_mem_slave_p (ID=1, DEPTH=128) with a small synchronous memory model.
module tb_apb_mem_slave_p;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int SW = 2;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  apb_mem_slave_p_if #(.DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .WAIT_W(WW)) bus ();

  logic          proto_err, mem_ce, mem_wren, mem_rden;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  apb_mem_slave_p #(
    .DATA_W(DW), .ADDR_W(AW), .SEL_W(SW), .ID(1), .DEPTH(128), .WAIT_W(WW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .proto_err (proto_err),
    .mem_ce    (mem_ce),
    .mem_wren  (mem_wren),
    .mem_rden  (mem_rden),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Memory model: one-cycle read latency, cleared while reset is held
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem_rdata <= 8'h00;
    end else begin
      if (mem_ce && mem_wren) mem[mem_addr] <= mem_wdata;
      if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; reports latency, first strobe cycle/kind, strobe count and response
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] w,
                      output int lat, output int strb_cyc, output int strb_n,
                      output logic [2:0] kind, output logic [7:0] rd, output logic err);
    lat = -1; strb_cyc = -1; strb_n = 0; kind = 3'b000; rd = 8'h00; err = 1'b0;
    bus.sel = 2'd1; bus.enable = 1'b0; bus.write = wr;
    bus.addr = a; bus.wdata = d; bus.wait_cycles = w;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    for (int k = 0; k < 300 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_ce || mem_wren || mem_rden) begin
        strb_n++;
        if (strb_cyc < 0) begin
          strb_cyc = k;
          kind = {mem_ce, mem_wren, mem_rden};
        end
      end
      if (bus.ready) begin
        lat = k + 1;
        rd  = bus.rdata;
        err = bus.slverr;
      end
    end
    @(posedge clk); #1;
    bus.sel = 2'd0; bus.enable = 1'b0;
  endtask

  task automatic run(input string tag, input logic wr, input logic [7:0] a, input logic [7:0] d,
                     input logic [7:0] w, input int exp_lat, input logic [2:0] exp_kind,
                     input logic [7:0] exp_rd, input logic exp_err);
    int lat, sc, sn;
    logic [2:0] kind;
    logic [7:0] rd;
    logic err;
    xfer(wr, a, d, w, lat, sc, sn, kind, rd, err);
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    if (exp_kind != 3'b000) begin
      check_eq({tag, "_strb_cyc"}, sc, {24'd0, w});
      check_eq({tag, "_strb_kind"}, {29'd0, kind}, {29'd0, exp_kind});
    end
    check_eq({tag, "_strb_n"}, sn, (exp_kind != 3'b000) ? 1 : 0);
    if (!wr) check_eq({tag, "_rdata"}, {24'd0, rd}, {24'd0, exp_rd});
  endtask

  // Watch n cycles for any strobe or ready; returns how many cycles showed activity
  task automatic watch(input int n, output int act);
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (mem_ce || mem_wren || mem_rden || bus.ready) act++;
    end
  endtask

  int act;

  initial begin
    reset = 1'b1;
    bus.sel = 2'd0; bus.enable = 1'b0; bus.write = 1'b0;
    bus.addr = 8'h00; bus.wdata = 8'h00; bus.wait_cycles = 8'h00;
    #2 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("rst_flags", {26'd0, bus.ready, bus.slverr, proto_err, mem_ce, mem_wren, mem_rden}, 32'd0);
    check_eq("rst_addr_wdata", {16'd0, mem_addr, mem_wdata}, 32'd0);
    check_eq("rst_rdata", {24'd0, bus.rdata}, 32'd0);
    reset = 1'b1;

    // In-range traffic, including the last legal address and maximum wait
    run("wr10_w0", 1'b1, 8'h10, 8'hA5, 8'd0, 2, 3'b110, 8'h00, 1'b0);
    check_eq("hold_addr_wdata", {16'd0, mem_addr, mem_wdata}, {16'd0, 8'h10, 8'hA5});
    run("rd10_w3", 1'b0, 8'h10, 8'h00, 8'd3, 6, 3'b101, 8'hA5, 1'b0);
    run("wr7f_w1", 1'b1, 8'h7F, 8'h3C, 8'd1, 3, 3'b110, 8'h00, 1'b0);
    run("rd7f_w0", 1'b0, 8'h7F, 8'h00, 8'd0, 3, 3'b101, 8'h3C, 1'b0);

    // Out-of-range: error, no strobes, rdata held on write and zeroed on read
    run("wr80_oor", 1'b1, 8'h80, 8'h77, 8'd0, 2, 3'b000, 8'h00, 1'b1);
    check_eq("rdata_hold", {24'd0, bus.rdata}, {24'd0, 8'h3C});
    run("rd80_oor", 1'b0, 8'h80, 8'h00, 8'd0, 2, 3'b000, 8'h00, 1'b1);
    run("rdff_oor_w4", 1'b0, 8'hFF, 8'h00, 8'd4, 6, 3'b000, 8'h00, 1'b1);

    run("wr05_wmax", 1'b1, 8'h05, 8'hC3, 8'd255, 257, 3'b110, 8'h00, 1'b0);
    run("rd05_w0", 1'b0, 8'h05, 8'h00, 8'd0, 3, 3'b101, 8'hC3, 1'b0);
    check_eq("no_proto_yet", {31'd0, proto_err}, 32'd0);

    // Foreign select code: nothing happens
    bus.sel = 2'd2; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h40; bus.wait_cycles = 8'd0;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    watch(5, act);
    check_eq("sel2_activity", act, 0);
    check_eq("sel2_proto", {31'd0, proto_err}, 32'd0);
    bus.sel = 2'd0; bus.enable = 1'b0;
    @(posedge clk); #1;

    // sel dropped during WAIT aborts the transfer
    bus.sel = 2'd1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h30;
    bus.wdata = 8'h11; bus.wait_cycles = 8'd5;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    watch(3, act);
    bus.sel = 2'd0;
    begin
      int act2;
      watch(10, act2);
      check_eq("abort_activity", act + act2, 0);
    end
    check_eq("abort_proto", {31'd0, proto_err}, 32'd1);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    run("rd10_after_abort", 1'b0, 8'h10, 8'h00, 8'd0, 3, 3'b101, 8'hA5, 1'b0);
    check_eq("proto_sticky", {31'd0, proto_err}, 32'd1);

    // Reset asserted during MEM of a write
    bus.sel = 2'd1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h20;
    bus.wdata = 8'h5A; bus.wait_cycles = 8'd0;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    check_eq("mid_wren_before", {30'd0, mem_ce, mem_wren}, 32'd3);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_flags", {26'd0, bus.ready, bus.slverr, proto_err, mem_ce, mem_wren, mem_rden}, 32'd0);
    check_eq("mid_rst_data", {8'd0, mem_addr, mem_wdata, bus.rdata}, 32'd0);
    bus.sel = 2'd0; bus.enable = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    watch(3, act);
    check_eq("post_rst_quiet", act, 0);
    run("wr20_w2", 1'b1, 8'h20, 8'h5A, 8'd2, 4, 3'b110, 8'h00, 1'b0);
    run("rd20_w1", 1'b0, 8'h20, 8'h00, 8'd1, 4, 3'b101, 8'h5A, 1'b0);
    check_eq("post_rst_proto", {31'd0, proto_err}, 32'd0);

    // Access phase without a setup phase
    bus.sel = 2'd1; bus.enable = 1'b1; bus.write = 1'b0; bus.addr = 8'h10; bus.wait_cycles = 8'd0;
    watch(4, act);
    bus.sel = 2'd0; bus.enable = 1'b0;
    watch(2, act);
    check_eq("nosetup_activity", act, 0);
    check_eq("nosetup_proto", {31'd0, proto_err}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
